// File: rtl/risc_alu.sv
// Registered 32-bit MIPS-style ALU: shift, mul/div, add/sub, logic and compare, one-cycle latency.
// Define RISC_ALU_MULDIV_EN to build the multiplier and divider; otherwise MUL/DIV return zero.
module risc_alu (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic [3:0]  ALU_OP,
  output logic [31:0] Result,
  output logic [31:0] Result2,
  output logic        OF,
  output logic        UOF,
  output logic        Equal
);

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRA  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  logic [31:0] res_d;
  logic [31:0] res2_d;
  logic        of_d;
  logic        uof_d;
  logic [32:0] sum_ext;
  logic [32:0] diff_ext;

  // Bit 32 of the extended sum is the carry; of the extended difference, the borrow.
  assign sum_ext  = {1'b0, X} + {1'b0, Y};
  assign diff_ext = {1'b0, X} - {1'b0, Y};

`ifdef RISC_ALU_MULDIV_EN
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;

  assign product   = {32'd0, X} * {32'd0, Y};
  assign quotient  = (Y == 32'd0) ? 32'hFFFF_FFFF : X / Y;
  assign remainder = (Y == 32'd0) ? X : X % Y;
`endif

  always_comb begin
    res_d  = 32'd0;
    res2_d = 32'd0;
    of_d   = 1'b0;
    uof_d  = 1'b0;
    case (ALU_OP)
      OP_SLL: res_d = X << Y[4:0];
      OP_SRA: res_d = $signed(X) >>> Y[4:0];
      OP_SRL: res_d = X >> Y[4:0];
`ifdef RISC_ALU_MULDIV_EN
      OP_MUL: begin
        res_d  = product[31:0];
        res2_d = product[63:32];
      end
      OP_DIV: begin
        res_d  = quotient;
        res2_d = remainder;
      end
`endif
      OP_ADD: begin
        res_d = sum_ext[31:0];
        uof_d = sum_ext[32];
        of_d  = (X[31] == Y[31]) && (sum_ext[31] != X[31]);
      end
      OP_SUB: begin
        res_d = diff_ext[31:0];
        uof_d = diff_ext[32];
        of_d  = (X[31] != Y[31]) && (diff_ext[31] != X[31]);
      end
      OP_AND:  res_d = X & Y;
      OP_OR:   res_d = X | Y;
      OP_XOR:  res_d = X ^ Y;
      OP_NOR:  res_d = ~(X | Y);
      OP_SLT:  res_d = {31'd0, $signed(X) < $signed(Y)};
      OP_SLTU: res_d = {31'd0, X < Y};
      default: res_d = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      Result  <= 32'd0;
      Result2 <= 32'd0;
      OF      <= 1'b0;
      UOF     <= 1'b0;
      Equal   <= 1'b0;
    end else begin
      Result  <= res_d;
      Result2 <= res2_d;
      OF      <= of_d;
      UOF     <= uof_d;
      Equal   <= (X == Y);
    end
  end

endmodule

// File: tb/tb_risc_alu.sv
// Self-checking bench for risc_alu: directed steps feed an expected-result queue checked each cycle.
module tb_risc_alu;

  logic        clock;
  logic        reset_n;
  logic [31:0] X;
  logic [31:0] Y;
  logic [3:0]  ALU_OP;
  logic [31:0] Result;
  logic [31:0] Result2;
  logic        OF;
  logic        UOF;
  logic        Equal;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] res2;
    logic        of;
    logic        uof;
    logic        eq;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0;
  int   fail_count  = 0;

  localparam logic [3:0] OP_SLL  = 4'b0000;
  localparam logic [3:0] OP_SRA  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  risc_alu dut (
    .clock   (clock),
    .reset_n (reset_n),
    .X       (X),
    .Y       (Y),
    .ALU_OP  (ALU_OP),
    .Result  (Result),
    .Result2 (Result2),
    .OF      (OF),
    .UOF     (UOF),
    .Equal   (Equal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference for add/sub flags uses wide signed/unsigned arithmetic rather than bit tricks.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] res, output logic of, output logic uof);
    longint          sx, sy, s;
    longint unsigned ux, uy;
    sx  = $signed(x);
    sy  = $signed(y);
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    res = 32'd0;
    of  = 1'b0;
    uof = 1'b0;
    case (op)
      OP_ADD: begin
        s   = sx + sy;
        res = x + y;
        of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        uof = (ux + uy) > 64'h0000_0000_FFFF_FFFF;
      end
      OP_SUB: begin
        s   = sx - sy;
        res = x - y;
        of  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        uof = ux < uy;
      end
      OP_XOR:  res = x ^ y;
      OP_OR:   res = x | y;
      OP_SLTU: res = (ux < uy) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input logic rst_n, input logic [3:0] op,
                               input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] res, input logic [31:0] res2,
                               input logic of, input logic uof);
    exp_t e;
    reset_n = rst_n;
    ALU_OP  = op;
    X       = x;
    Y       = y;
    e.tag   = tag;
    if (!rst_n) begin
      e.res  = 32'd0;
      e.res2 = 32'd0;
      e.of   = 1'b0;
      e.uof  = 1'b0;
      e.eq   = 1'b0;
    end else begin
      e.res  = res;
      e.res2 = res2;
      e.of   = of;
      e.uof  = uof;
      e.eq   = (x == y);
    end
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    check_count++;
    assert (exp_q.size() != 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_empty observed size 0 expected >0");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_count++;
      assert (Result === e.res) else begin
        fail_count++;
        $error("[TB] FAIL %s.Result observed %h expected %h", e.tag, Result, e.res);
      end
      check_count++;
      assert (Result2 === e.res2) else begin
        fail_count++;
        $error("[TB] FAIL %s.Result2 observed %h expected %h", e.tag, Result2, e.res2);
      end
      check_count++;
      assert (OF === e.of) else begin
        fail_count++;
        $error("[TB] FAIL %s.OF observed %b expected %b", e.tag, OF, e.of);
      end
      check_count++;
      assert (UOF === e.uof) else begin
        fail_count++;
        $error("[TB] FAIL %s.UOF observed %b expected %b", e.tag, UOF, e.uof);
      end
      check_count++;
      assert (Equal === e.eq) else begin
        fail_count++;
        $error("[TB] FAIL %s.Equal observed %b expected %b", e.tag, Equal, e.eq);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    checkOutput();
  endtask

  initial begin
    logic [31:0] rx, ry, rres;
    logic        rof, ruof;
    logic [3:0]  rop;
    logic [31:0] mul_lo, mul_hi, div_q, div_r, div0_q, div0_r;
    logic [3:0]  rand_ops [5];

`ifdef RISC_ALU_MULDIV_EN
    mul_lo = 32'd10872; mul_hi = 32'd0;
    div_q  = 32'd56;    div_r  = 32'd5;
    div0_q = 32'hFFFF_FFFF; div0_r = 32'd7;
`else
    mul_lo = 32'd0; mul_hi = 32'd0;
    div_q  = 32'd0; div_r  = 32'd0;
    div0_q = 32'd0; div0_r = 32'd0;
`endif

    $display("[TB] starting risc_alu directed sequence");

    applyStimulus("reset",     1'b0, OP_ADD, 32'd5, 32'd5, 0, 0, 0, 0);                           step();
    applyStimulus("post_rst",  1'b1, OP_ADD, 32'd5, 32'd5, 32'd10, 0, 0, 0);                      step();

    applyStimulus("sll",       1'b1, OP_SLL, 32'd13, 32'd264197, 32'd416, 0, 0, 0);               step();
    applyStimulus("srl",       1'b1, OP_SRL, 32'd3358, 32'd265221, 32'd104, 0, 0, 0);             step();
    applyStimulus("sra_neg",   1'b1, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 0);       step();
    applyStimulus("sra_pos",   1'b1, OP_SRA, 32'h7000_0000, 32'd31, 32'd0, 0, 0, 0);              step();

    applyStimulus("mul",       1'b1, OP_MUL, 32'd24, 32'd453, mul_lo, mul_hi, 0, 0);              step();
    applyStimulus("div",       1'b1, OP_DIV, 32'd677, 32'd12, div_q, div_r, 0, 0);                step();
    applyStimulus("div0",      1'b1, OP_DIV, 32'd7, 32'd0, div0_q, div0_r, 0, 0);                 step();

    applyStimulus("add_of",    1'b1, OP_ADD, 32'd1613496997, 32'd1343234060, 32'd2956731057, 0, 1, 0); step();
    applyStimulus("add_carry", 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1);               step();
    applyStimulus("sub_of",    1'b1, OP_SUB, 32'd2147483648, 32'd1879050244, 32'd268433404, 0, 1, 0); step();
    applyStimulus("sub_plain", 1'b1, OP_SUB, 32'd45634, 32'd11232, 32'd34402, 0, 0, 0);           step();
    applyStimulus("sub_borrow",1'b1, OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 1);               step();

    applyStimulus("and",       1'b1, OP_AND, 32'd618, 32'd8284, 32'd618 & 32'd8284, 0, 0, 0);     step();
    applyStimulus("nor",       1'b1, OP_NOR, 32'd618, 32'd172, 32'hFFFF_FD11, 0, 0, 0);           step();
    applyStimulus("slt",       1'b1, OP_SLT, 32'd1256981157, 32'd2147484852, 32'd0, 0, 0, 0);     step();
    applyStimulus("sltu",      1'b1, OP_SLTU, 32'd1256981157, 32'd2147484852, 32'd1, 0, 0, 0);    step();
    applyStimulus("undef_eq",  1'b1, 4'b1101, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 0, 0, 0);      step();
    applyStimulus("undef_f",   1'b1, 4'b1111, 32'd9, 32'd8, 32'd0, 0, 0, 0);                      step();

    // Reset dropped mid-stream, then the first released edge must register the live operation.
    applyStimulus("mid_reset", 1'b0, OP_XOR, 32'd1, 32'd1, 0, 0, 0, 0);                           step();
    applyStimulus("mid_rel",   1'b1, OP_OR, 32'h00F0_0000, 32'h0000_000F, 32'h00F0_000F, 0, 0, 0); step();

    rand_ops[0] = OP_ADD; rand_ops[1] = OP_SUB; rand_ops[2] = OP_XOR;
    rand_ops[3] = OP_OR;  rand_ops[4] = OP_SLTU;
    for (int i = 0; i < 10; i++) begin
      rop = rand_ops[$urandom_range(0, 4)];
      rx  = $urandom;
      ry  = (i == 3) ? rx : $urandom;
      ref_model(rop, rx, ry, rres, rof, ruof);
      applyStimulus("random", 1'b1, rop, rx, ry, rres, 0, rof, ruof);
      step();
    end

    check_count++;
    assert (exp_q.size() == 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
